// File: rtl/jb_axi4_stream_if.sv
// rtl/jb_axi4_stream_if.sv - AXI4-Stream style lane carrying tvalid/tready/tdata
//
// Signals:
//   tvalid  master -> slave  beat valid
//   tready  slave -> master  beat accepted when tvalid && tready
//   tdata   master -> slave  payload, DATA_WIDTH bits
interface jb_axi4_stream_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/jb_dl_dac_aligner.sv
// rtl/jb_dl_dac_aligner.sv - per-antenna lane FIFOs released to the DAC sample-aligned
//
// Buffers each DL DFE output lane in its own FIFO and releases all lanes
// together once every lane holds START_LEVEL words. If any lane runs dry
// while running, all FIFOs are flushed and alignment is re-acquired.
//
// Ports:
//   clk_4x            in   sole clock
//   reset             in   asynchronous active-high reset
//   enable            in   aligner enable; low returns to IDLE and flushes
//   IFP_dl_dfe_out    slave lanes [N_ANTENNAS], tvalid/tready/tdata
//   dac_data          out  lane a at [a*DATA_WIDTH +: DATA_WIDTH], zero when not valid
//   dac_valid         out  aligned data valid (one cycle after the pop)
//   aligned           out  registered, high while in RUN
//   underflow_sticky  out  set on underflow, cleared by clr_stat (set wins)
//   clr_stat          in   single-cycle status clear
//   fill_level        out  per-lane registered word count, $clog2(FIFO_DEPTH)+1 bits each
//   underflow_cnt     out  16-bit saturating underflow counter, only when
//                          JB_DL_DAC_ALIGN_UFCNT_EN is defined
module jb_dl_dac_aligner #(
    parameter int N_ANTENNAS  = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 8
) (
    input  logic                                          clk_4x,
    input  logic                                          reset,
    input  logic                                          enable,
    jb_axi4_stream_if.slave                               IFP_dl_dfe_out [N_ANTENNAS-1:0],
    output logic [N_ANTENNAS*DATA_WIDTH-1:0]              dac_data,
    output logic                                          dac_valid,
    output logic                                          aligned,
    output logic                                          underflow_sticky,
    input  logic                                          clr_stat,
    output logic [N_ANTENNAS*($clog2(FIFO_DEPTH)+1)-1:0]  fill_level
`ifdef JB_DL_DAC_ALIGN_UFCNT_EN
    ,
    output logic [15:0]                                   underflow_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] START_C = CW'(START_LEVEL);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  dac_valid_q;
    logic                  aligned_q;
    logic                  sticky_q, sticky_d;

    logic [N_ANTENNAS-1:0] lane_ready_w;
    logic [N_ANTENNAS-1:0] lane_empty_w;
    logic                  all_ready_w;
    logic                  any_empty_w;
    logic                  underflow_w;
    logic                  pop_w;
    logic                  flush_w;

    assign all_ready_w = &lane_ready_w;
    assign any_empty_w = |lane_empty_w;

    // Underflow looks at registered counts only, before any same-cycle push.
    assign underflow_w = enable && (state_q == ST_RUN) && any_empty_w;

    // The cycle FILL sees every lane at START_LEVEL is already the first pop,
    // so data reaches the DAC one cycle later rather than two.
    assign pop_w = enable && !any_empty_w &&
                   ((state_q == ST_RUN) || ((state_q == ST_FILL) && all_ready_w));

    // IDLE keeps the FIFOs empty; disable and underflow drop everything.
    assign flush_w = !enable || (state_q == ST_IDLE) || underflow_w;

    for (genvar a = 0; a < N_ANTENNAS; a++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [CW-1:0]         count_q, count_d;
        logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic                  tready_w;
        logic                  push_w;

        // Full decision is on the registered count, even if a pop happens now.
        assign tready_w = (state_q == ST_IDLE) || (count_q < DEPTH_C);
        assign push_w   = IFP_dl_dfe_out[a].tvalid && tready_w && !flush_w;

        assign IFP_dl_dfe_out[a].tready = tready_w;
        assign lane_ready_w[a]          = (count_q >= START_C);
        assign lane_empty_w[a]          = (count_q == '0);

        always_comb begin
            count_d  = count_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            data_d   = pop_w ? mem_q[rd_ptr_q] : '0;
            if (flush_w) begin
                count_d  = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
                if (push_w && !pop_w) count_d = count_q + 1'b1;
                if (!push_w && pop_w) count_d = count_q - 1'b1;
            end
        end

        always_ff @(posedge clk_4x or posedge reset) begin
            if (reset) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                data_q   <= '0;
            end else begin
                count_q  <= count_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                data_q   <= data_d;
            end
        end

        // Storage needs no reset: count and pointers define what is valid.
        always_ff @(posedge clk_4x) begin
            if (push_w) mem_q[wr_ptr_q] <= IFP_dl_dfe_out[a].tdata;
        end

        assign dac_data[a*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign fill_level[a*CW +: CW]               = count_q;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FILL;
                ST_FILL: if (all_ready_w) state_d = ST_RUN;
                ST_RUN:  if (any_empty_w) state_d = ST_FILL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        if (underflow_w)   sticky_d = 1'b1;
        else if (clr_stat) sticky_d = 1'b0;
    end

    always_ff @(posedge clk_4x or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dac_valid_q <= 1'b0;
            aligned_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dac_valid_q <= pop_w;
            aligned_q   <= (state_d == ST_RUN);
            sticky_q    <= sticky_d;
        end
    end

    assign dac_valid        = dac_valid_q;
    assign aligned          = aligned_q;
    assign underflow_sticky = sticky_q;

`ifdef JB_DL_DAC_ALIGN_UFCNT_EN
    logic [15:0] ufcnt_q, ufcnt_d;

    // A clear in the same cycle as an underflow counts that underflow.
    always_comb begin
        ufcnt_d = ufcnt_q;
        if (clr_stat)
            ufcnt_d = underflow_w ? 16'd1 : 16'd0;
        else if (underflow_w && (ufcnt_q != 16'hFFFF))
            ufcnt_d = ufcnt_q + 16'd1;
    end

    always_ff @(posedge clk_4x or posedge reset) begin
        if (reset) ufcnt_q <= '0;
        else       ufcnt_q <= ufcnt_d;
    end

    assign underflow_cnt = ufcnt_q;
`endif

endmodule

// File: tb/tb_jb_dl_dac_aligner.sv
// tb/tb_jb_dl_dac_aligner.sv - self-checking bench for jb_dl_dac_aligner
module tb_jb_dl_dac_aligner;
    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int SL    = 8;
    localparam int CW    = 5;

    logic clk_4x = 1'b0;
    always #5 clk_4x = ~clk_4x;

    logic            reset, enable, clr_stat;
    logic [N-1:0]    tv, tr;
    logic [DW-1:0]   td [N];
    logic [N*DW-1:0] dac_data;
    logic            dac_valid, aligned, underflow_sticky;
    logic [N*CW-1:0] fill_level;
`ifdef JB_DL_DAC_ALIGN_UFCNT_EN
    logic [15:0]     underflow_cnt;
`endif

    jb_axi4_stream_if #(.DATA_WIDTH(DW)) lanes [N-1:0] ();

    for (genvar g = 0; g < N; g++) begin : g_if
        assign lanes[g].tvalid = tv[g];
        assign lanes[g].tdata  = td[g];
        assign tr[g]           = lanes[g].tready;
    end

    jb_dl_dac_aligner #(
        .N_ANTENNAS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .START_LEVEL(SL)
    ) dut (
        .clk_4x(clk_4x),
        .reset(reset),
        .enable(enable),
        .IFP_dl_dfe_out(lanes),
        .dac_data(dac_data),
        .dac_valid(dac_valid),
        .aligned(aligned),
        .underflow_sticky(underflow_sticky),
        .clr_stat(clr_stat),
        .fill_level(fill_level)
`ifdef JB_DL_DAC_ALIGN_UFCNT_EN
        ,
        .underflow_cnt(underflow_cnt)
`endif
    );

    // Reference model: mode 0 = idle, 1 = waiting for START_LEVEL, 2 = streaming.
    int            mode;
    logic [DW-1:0] mq [N][$];
    logic [DW-1:0] m_data [N];
    bit            m_valid, m_sticky;
    int            m_ufcnt;
    logic [DW-1:0] seq [N];
    bit            rnd_data;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0][7:0] dly;
        logic [7:0]      rise;
        logic [3:0][7:0] lvl;
    } row_t;
    row_t tbl [4];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = 0; m_valid = 0; m_sticky = 0; m_ufcnt = 0;
        for (int a = 0; a < N; a++) begin
            mq[a].delete();
            m_data[a] = '0;
            seq[a]    = '0;
        end
    endtask

    task automatic check_outputs();
        chk("dac_valid", 64'(dac_valid), 64'(m_valid));
        chk("aligned", 64'(aligned), 64'(mode == 2));
        chk("underflow_sticky", 64'(underflow_sticky), 64'(m_sticky));
        for (int a = 0; a < N; a++) begin
            chk($sformatf("fill_level[%0d]", a), 64'(fill_level[a*CW +: CW]), 64'(mq[a].size()));
            chk($sformatf("dac_data[%0d]", a), dac_data[a*DW +: DW], m_data[a]);
        end
`ifdef JB_DL_DAC_ALIGN_UFCNT_EN
        chk("underflow_cnt", 64'(underflow_cnt), 64'(m_ufcnt));
`endif
    endtask

    // One clock: check tready, advance the model, clock the DUT, compare outputs.
    task automatic cycle();
        bit rdy [N];
        bit acc [N];
        bit all_lvl, any_dry, uf, rel;
        for (int a = 0; a < N; a++) td[a] = rnd_data ? {$urandom, $urandom} : seq[a];
        #1;
        all_lvl = 1; any_dry = 0;
        for (int a = 0; a < N; a++) begin
            rdy[a] = (mode == 0) || (mq[a].size() < DEPTH);
            chk($sformatf("tready[%0d]", a), 64'(tr[a]), 64'(rdy[a]));
            acc[a] = tv[a] && rdy[a];
            if (mq[a].size() < SL) all_lvl = 0;
            if (mq[a].size() == 0) any_dry = 1;
        end
        uf  = enable && (mode == 2) && any_dry;
        rel = enable && !any_dry && ((mode == 2) || (mode == 1 && all_lvl));
        for (int a = 0; a < N; a++) m_data[a] = rel ? mq[a].pop_front() : '0;
        m_valid = rel;
        for (int a = 0; a < N; a++) begin
            if (!enable || mode == 0 || uf) mq[a].delete();
            else if (acc[a]) mq[a].push_back(td[a]);
            if (acc[a] && !rnd_data) seq[a] = seq[a] + 1;
        end
        if (!enable)                  mode = 0;
        else if (mode == 0)           mode = 1;
        else if (mode == 1 && all_lvl) mode = 2;
        else if (uf)                  mode = 1;
        if (uf)            m_sticky = 1;
        else if (clr_stat) m_sticky = 0;
        if (clr_stat)                  m_ufcnt = uf ? 1 : 0;
        else if (uf && m_ufcnt < 65535) m_ufcnt++;
        @(posedge clk_4x);
        @(negedge clk_4x);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; clr_stat = 0; tv = '0; rnd_data = 0;
        @(negedge clk_4x);
        @(negedge clk_4x);
        model_reset();
        check_outputs();
        reset = 0;
    endtask

    task automatic set_row(input int i, input int d0, input int d1, input int d2, input int d3,
                           input int r, input int l0, input int l1, input int l2, input int l3);
        tbl[i].dly[0] = 8'(d0); tbl[i].dly[1] = 8'(d1); tbl[i].dly[2] = 8'(d2); tbl[i].dly[3] = 8'(d3);
        tbl[i].rise   = 8'(r);
        tbl[i].lvl[0] = 8'(l0); tbl[i].lvl[1] = 8'(l1); tbl[i].lvl[2] = 8'(l2); tbl[i].lvl[3] = 8'(l3);
    endtask

    // Enable, let each lane start after its delay, measure dac_valid rise.
    task automatic run_row(input int r);
        int rise;
        do_reset();
        enable = 1;
        cycle();
        rise = -1;
        for (int t = 0; t < 40 && rise < 0; t++) begin
            for (int a = 0; a < N; a++) tv[a] = (t >= int'(tbl[r].dly[a]));
            cycle();
            if (dac_valid) rise = t + 1;
        end
        chk($sformatf("row%0d rise cycle", r), 64'(rise), 64'(tbl[r].rise));
        if (rise >= 0) begin
            chk($sformatf("row%0d aligned", r), 64'(aligned), 64'd1);
            for (int a = 0; a < N; a++) begin
                chk($sformatf("row%0d level[%0d]", r, a), 64'(fill_level[a*CW +: CW]), 64'(tbl[r].lvl[a]));
                chk($sformatf("row%0d first word[%0d]", r, a), dac_data[a*DW +: DW], 64'd0);
            end
        end
    endtask

    // Stream until dac_valid appears; returns the 0-based cycle index or -1.
    task automatic wait_valid(input int limit, output int k_rise);
        k_rise = -1;
        for (int k = 0; k < limit && k_rise < 0; k++) begin
            cycle();
            if (dac_valid) k_rise = k;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int j_uf, k;
        for (int a = 0; a < N; a++) td[a] = '0;
        set_row(0, 0, 0, 0, 0,  9,  8,  8,  8,  8);
        set_row(1, 0, 0, 5, 0, 14, 13, 13,  8, 13);
        set_row(2, 3, 1, 0, 2, 12,  8, 10, 11,  9);
        set_row(3, 0, 7, 2, 4, 16, 15,  8, 13, 11);

        for (int r = 0; r < 4; r++) run_row(r);

        // Lane 1 starves in RUN: underflow on the 9th idle cycle, then re-align.
        run_row(0);
        tv = '1;
        repeat (5) cycle();
        tv[1] = 1'b0;
        j_uf = -1;
        for (int j = 0; j < 10; j++) begin
            cycle();
            if (underflow_sticky && j_uf < 0) begin
                j_uf = j;
                chk("uf dac_valid", 64'(dac_valid), 64'd0);
                chk("uf aligned", 64'(aligned), 64'd0);
                for (int a = 0; a < N; a++)
                    chk($sformatf("uf level[%0d]", a), 64'(fill_level[a*CW +: CW]), 64'd0);
            end
        end
        chk("uf cycle", 64'(j_uf), 64'd8);
        tv = '1;
        wait_valid(30, k);
        chk("realign cycle", 64'(k), 64'd8);
        chk("realign level[0]", 64'(fill_level[0 +: CW]), 64'd9);
        chk("realign level[1]", 64'(fill_level[CW +: CW]), 64'd8);

        // Lane 3 idle: lanes 0-2 fill to the brim and stall.
        do_reset();
        enable = 1;
        cycle();
        tv = 4'b0111;
        repeat (25) cycle();
        for (int a = 0; a < 3; a++)
            chk($sformatf("full level[%0d]", a), 64'(fill_level[a*CW +: CW]), 64'd16);
        chk("full level[3]", 64'(fill_level[3*CW +: CW]), 64'd0);
        chk("full tready", 64'(tr), 64'(4'b1000));
        tv = '1;
        wait_valid(20, k);
        chk("full release cycle", 64'(k), 64'd8);
        chk("full first word[0]", dac_data[0 +: DW], 64'd0);
        repeat (20) cycle();

        // Enable drop mid-RUN, then a fresh fill.
        enable = 0;
        cycle();
        chk("disable aligned", 64'(aligned), 64'd0);
        chk("disable dac_valid", 64'(dac_valid), 64'd0);
        chk("disable dac_data", 64'(|dac_data), 64'd0);
        chk("disable level[0]", 64'(fill_level[0 +: CW]), 64'd0);
        #1;
        chk("disable tready", 64'(tr), 64'hF);
        cycle();
        enable = 1;
        cycle();
        wait_valid(30, k);
        chk("re-enable release cycle", 64'(k), 64'd8);
        repeat (3) cycle();

        // Asynchronous reset in RUN.
        #2 reset = 1;
        #1;
        chk("async dac_valid", 64'(dac_valid), 64'd0);
        chk("async aligned", 64'(aligned), 64'd0);
        chk("async dac_data", 64'(|dac_data), 64'd0);
        chk("async fill_level", 64'(fill_level), 64'd0);
        @(negedge clk_4x);
        model_reset();
        reset = 0;
        repeat (14) cycle();

`ifdef JB_DL_DAC_ALIGN_UFCNT_EN
        do_reset();
        enable = 1;
        cycle();
        for (int n = 0; n < 4; n++) begin
            tv = '1;
            repeat (12) cycle();
            tv = '0;
            for (int j = 0; j < 10; j++) begin
                clr_stat = (n == 3 && j == 8);
                cycle();
                clr_stat = 0;
            end
            if (n == 2) chk("ufcnt after 3", 64'(underflow_cnt), 64'd3);
        end
        chk("ufcnt clr+uf", 64'(underflow_cnt), 64'd1);
        chk("sticky clr+uf", 64'(underflow_sticky), 64'd1);
`endif

        // Randomised traffic against the model.
        do_reset();
        rnd_data = 1;
        enable   = 1;
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 299) != 0);
            clr_stat = ($urandom_range(0, 39) == 0);
            for (int a = 0; a < N; a++)
                tv[a] = ($urandom_range(0, 99) < ((i % 500) < 250 ? 97 : 75));
            cycle();
        end
        clr_stat = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jb_dl_dac_aligner.md
# jb_dl_dac_aligner

Downstream of the DL DFE output delay stage: consumes the per-antenna 64-bit DFE output streams and feeds the DAC data path. Each antenna lane is buffered in its own FIFO. The block releases all lanes to the DAC together, only once every lane has reached a start threshold, so antennas leave sample-aligned. If any lane runs dry, an underflow is detected, all lanes are flushed, and alignment is re-acquired.

## Interface
Parameters:
- N_ANTENNAS, 4, number of antenna lanes
- DATA_WIDTH, 64, tdata width per lane (two {q,i} 16-bit sample pairs)
- FIFO_DEPTH, 16, words per lane FIFO (power of two, ≥4)
- START_LEVEL, 8, words required in every lane before release (1..FIFO_DEPTH)

Ports:
- clk_4x  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  aligner enable (synchronous to clk_4x)
- IFP_dl_dfe_out[N_ANTENNAS-1:0]  jb_axi4_stream_if.slave  DATA_WIDTH  per-lane input (tvalid/tready/tdata; tuser/tlast ignored)
- dac_data  out  N_ANTENNAS*DATA_WIDTH  lane a at bits [a*DATA_WIDTH +: DATA_WIDTH]
- dac_valid  out  1  aligned data valid
- aligned  out  1  state == RUN
- underflow_sticky  out  1  set on underflow, cleared by clr_stat
- clr_stat  in  1  single-cycle pulse, clears status
- fill_level  out  N_ANTENNAS*($clog2(FIFO_DEPTH)+1)  per-lane registered word count

## Operation
- States: IDLE, FILL, RUN.
- Reset values: state = IDLE, all counts 0, dac_data = 0, dac_valid = 0, aligned = 0, underflow_sticky = 0.
- IDLE
  - tready = 1 on all lanes; accepted beats are discarded; FIFOs held empty.
  - enable = 1 → FILL.
- FILL
  - tready[a] = (count[a] < FIFO_DEPTH); no pops.
  - All count[a] ≥ START_LEVEL → RUN.
- RUN
  - Every cycle, all lanes pop together, one word each; popped words form the dac_data of the following cycle.
  - Any count[a] == 0 (registered value, evaluated before same-cycle push) → underflow:
    - set underflow_sticky;
    - flush all FIFOs (all counts → 0 next cycle);
    - go to FILL;
    - no pop that cycle.
- enable = 0 in any state → IDLE next cycle; FIFOs flushed.
- Push/pop rules:
  - Full decision uses the registered count: at count == FIFO_DEPTH, tready = 0 even if a pop occurs the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Outside RUN, dac_data is driven to 0 and dac_valid = 0.
- clr_stat coinciding with a new underflow: the set wins.

## Timing
- Status outputs aligned and fill_level are registered.
- dac_data and dac_valid are registered, with 1 cycle latency after the pop.
  - Entry to RUN at cycle T: first pop at T, dac_valid = 1 from T+1.
- Minimum input-to-DAC latency: beat accepted at cycle t is countable at t+1.
  - With START_LEVEL words back-to-back on all lanes, the last accept is at t0+START_LEVEL-1, RUN starts at t0+START_LEVEL, and dac_valid rises at t0+START_LEVEL+1.
- Underflow at cycle U:
  - dac_valid = 0 from U+1;
  - state = FILL at U+1;
  - a beat presented at U is dropped by the flush.
- Reset asserted mid-RUN: all outputs return to reset values immediately (asynchronously); no DAC data leaks after deassert until a full FILL completes.

## Configuration
- JB_DL_DAC_ALIGN_UFCNT_EN defined:
  - adds output underflow_cnt (16 bits, reset 0);
  - increments once per underflow event and saturates at 0xFFFF;
  - cleared by clr_stat;
  - clr_stat coinciding with an underflow event loads 1.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then enable = 1, all 4 lanes stream an incrementing pattern continuously → dac_valid rises 9 cycles after the first accepted beat; lane words are identical per cycle; aligned = 1.
- Lane 2 starts 5 cycles after lanes 0, 1, 3 → RUN entered only when lane 2 reaches 8 words; lanes 0/1/3 hold 13 words; output shows lanes equal index-for-index.
- In RUN, lane 1 tvalid deasserted for 10 cycles → underflow_sticky = 1, dac_valid = 0 the next cycle, all fill_level = 0, then re-FILL and RUN after lane 1 resumes and 8 words accumulate.
- Outputs not consumed (no RUN because lane 3 idle), lanes 0–2 pushing → those lanes fill to 16, then tready = 0; no data lost or overwritten; count never exceeds 16.
- enable dropped mid-RUN → IDLE next cycle, tready = 1 with data discarded, dac_data = 0; re-enable gives a fresh FILL.
- With JB_DL_DAC_ALIGN_UFCNT_EN: force 3 underflows, then clr_stat in the same cycle as a 4th → underflow_cnt reads 3, then 1.
